// File: rtl/pram_pkg.sv
// Shared types and elaboration helpers for the windowed program memory.
package pram_pkg;

  typedef enum logic {
    PRAM_IDLE = 1'b0,
    PRAM_LOAD = 1'b1
  } pram_state_e;

  function automatic int unsigned pram_depth(input int unsigned addr_w);
    return 32'd1 << addr_w;
  endfunction

  function automatic bit pram_fetch_n_ok(input int unsigned fetch_n, input int unsigned depth);
    return (fetch_n >= 1) && (fetch_n <= depth);
  endfunction

endpackage

// File: rtl/pram_array.sv
// DEPTH x DATA_W storage: one synchronous write port, FETCH_N registered read
// ports reading consecutive words from a common base with natural address wrap.
module pram_array
  import pram_pkg::*;
#(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned ADDR_W  = 9,
  parameter int unsigned FETCH_N = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      we,
  input  logic [ADDR_W-1:0]         waddr,
  input  logic [DATA_W-1:0]         wdata,
  input  logic                      re,
  input  logic [ADDR_W-1:0]         raddr,
  output logic [FETCH_N*DATA_W-1:0] rdata
);

  localparam int unsigned DEPTH = pram_depth(ADDR_W);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] rd_addr [FETCH_N];

  // ADDR_W-bit sum wraps modulo DEPTH on its own.
  always_comb begin
    for (int unsigned k = 0; k < FETCH_N; k++) begin
      rd_addr[k] = raddr + ADDR_W'(k);
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      for (int unsigned k = 0; k < FETCH_N; k++) begin
        rdata[k*DATA_W +: DATA_W] <= mem[rd_addr[k]];
      end
    end
  end

endmodule

// File: rtl/pram_fetch.sv
// Program memory returning FETCH_N-word windows, written by a streaming loader
// with an auto-incrementing pointer; a two-state FSM arbitrates loads and fetches.
module pram_fetch
  import pram_pkg::*;
#(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned ADDR_W  = 9,
  parameter int unsigned FETCH_N = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ld_start,
  input  logic [ADDR_W-1:0]         ld_base,
  input  logic                      ld_valid,
  input  logic [DATA_W-1:0]         ld_data,
  input  logic                      ld_last,
  output logic                      ld_ready,
  output logic                      ld_busy,
  output logic [ADDR_W:0]           ld_count,
  input  logic                      fetch_req,
  input  logic [ADDR_W-1:0]         fetch_addr,
  output logic                      fetch_ready,
  output logic                      fetch_valid,
  output logic [FETCH_N*DATA_W-1:0] fetch_data,
  output logic [ADDR_W-1:0]         fetch_base
);

  localparam int unsigned DEPTH = pram_depth(ADDR_W);
  localparam logic [ADDR_W:0] COUNT_MAX = (ADDR_W+1)'(DEPTH);

  if (!pram_fetch_n_ok(FETCH_N, DEPTH)) begin : g_bad_fetch_n
    $error("pram_fetch: FETCH_N must be in 1..DEPTH");
  end

  pram_state_e       state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              fetch_valid_q;
  logic [ADDR_W-1:0] fetch_base_q;
  logic              wr_en;
  logic              fetch_acc;

  assign ld_ready    = (state_q == PRAM_LOAD);
  assign ld_busy     = (state_q == PRAM_LOAD);
  assign fetch_ready = (state_q == PRAM_IDLE);
  assign ld_count    = count_q;
  assign fetch_valid = fetch_valid_q;
  assign fetch_base  = fetch_base_q;

  assign wr_en     = ld_valid & ld_ready;
  assign fetch_acc = fetch_req & fetch_ready;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    count_d = count_q;
    unique case (state_q)
      PRAM_IDLE: begin
        if (ld_start) begin
          state_d = PRAM_LOAD;
          ptr_d   = ld_base;
          count_d = '0;
        end
      end
      PRAM_LOAD: begin
        if (wr_en) begin
          ptr_d = ptr_q + ADDR_W'(1);
          if (count_q != COUNT_MAX) begin
            count_d = count_q + (ADDR_W+1)'(1);
          end
          if (ld_last) begin
            state_d = PRAM_IDLE;
          end
        end
      end
      default: state_d = PRAM_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= PRAM_IDLE;
      ptr_q         <= '0;
      count_q       <= '0;
      fetch_valid_q <= 1'b0;
      fetch_base_q  <= '0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      count_q       <= count_d;
      fetch_valid_q <= fetch_acc;
      if (fetch_acc) begin
        fetch_base_q <= fetch_addr;
      end
    end
  end

  // Writes occur only in LOAD and reads only in IDLE, so the ports never collide.
  pram_array #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .FETCH_N (FETCH_N)
  ) u_array (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_en),
    .waddr (ptr_q),
    .wdata (ld_data),
    .re    (fetch_acc),
    .raddr (fetch_addr),
    .rdata (fetch_data)
  );

endmodule
